// File: rtl/wb_memtest_master.sv
// wb_memtest_master: pipelined Wishbone initiator running a write-then-readback pattern test.
// Ports: clk, rst_n (sync, active low); start/start_addr/len/seed launch a run;
// busy/done/pass/bus_err/err_cnt report status; wb_* is the pipelined Wishbone initiator.
// Optional WB_MEMTEST_ERRLOG_EN adds fail_addr/fail_exp/fail_got (first miscompare log).
module wb_memtest_master #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       len,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              bus_err,
  output logic [15:0]       err_cnt,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [3:0]        wb_sel,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_stall
`ifdef WB_MEMTEST_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [31:0]       fail_exp,
  output logic [31:0]       fail_got
`endif
);
  typedef enum logic [2:0] {IDLE, WR, GAP, RD, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [15:0] len_r, iss, ack_idx, iss_n;
  logic [31:0] seed_r, exp_d;
  logic [3:0] outst, outst_n;
  logic fin_r, phase, acc, rsp, bad_rsp, last, rd_ack, miss;
  always_comb begin
    phase    = state == WR || state == RD;
    wb_cyc   = phase && (iss != len_r || outst != 4'd0);
    wb_stb   = phase && iss != len_r && outst < 4'(MAX_OUT);
    wb_we    = state == WR;
    wb_sel   = 4'hF;
    wb_adr   = phase ? base + ADDR_W'({iss, 2'b00}) : '0;
    wb_dat_o = wb_we ? seed_r ^ {iss, ~iss} : 32'h0;
    acc      = wb_stb && !wb_stall;
    rsp      = wb_cyc && (wb_ack || wb_err);
    bad_rsp  = wb_cyc && wb_err;
    iss_n    = iss + 16'(acc);
    outst_n  = outst + 4'(acc) - 4'(rsp);
    // phase ends on the edge that retires the final response, so no idle tail cycle
    last     = iss_n == len_r && outst_n == 4'd0;
    exp_d    = seed_r ^ {ack_idx, ~ack_idx};
    rd_ack   = state == RD && wb_cyc && wb_ack;
    miss     = rd_ack && wb_dat_i != exp_d;
    busy     = state != IDLE;
    done     = state == FIN;
    pass     = (fin_r || done) && err_cnt == 16'd0 && !bus_err;
    state_n  = state;
    case (state)
      IDLE:    state_n = start ? WR : IDLE;
      WR:      state_n = bad_rsp ? FIN : last ? GAP : WR;
      GAP:     state_n = RD;
      RD:      state_n = (bad_rsp || last) ? FIN : RD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base    <= '0;
      len_r   <= '0;
      seed_r  <= '0;
      iss     <= '0;
      ack_idx <= '0;
      outst   <= '0;
      err_cnt <= '0;
      bus_err <= 1'b0;
      fin_r   <= 1'b0;
`ifdef WB_MEMTEST_ERRLOG_EN
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        base    <= start_addr & ~ADDR_W'(3);
        len_r   <= len;
        seed_r  <= seed;
        iss     <= '0;
        ack_idx <= '0;
        outst   <= '0;
        err_cnt <= '0;
        bus_err <= 1'b0;
        fin_r   <= 1'b0;
`ifdef WB_MEMTEST_ERRLOG_EN
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
`endif
      end
    end else if (state == GAP) begin
      iss     <= '0;
      ack_idx <= '0;
      outst   <= '0;
    end else if (phase) begin
      iss   <= iss_n;
      outst <= outst_n;
      if (rd_ack) ack_idx <= ack_idx + 16'd1;
      if (miss && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (bad_rsp) bus_err <= 1'b1;
`ifdef WB_MEMTEST_ERRLOG_EN
      // err_cnt is still zero only on the first miscompare of the run
      if (miss && err_cnt == 16'd0) begin
        fail_addr <= base + ADDR_W'({ack_idx, 2'b00});
        fail_exp  <= exp_d;
        fail_got  <= wb_dat_i;
      end
`endif
    end else if (state == FIN) begin
      fin_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_memtest_master.sv
// tb_wb_memtest_master: randomized self-checking bench with a Wishbone RAM responder model.
module tb_wb_memtest_master;
  localparam int LIMIT = 5000;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] start_addr = 0, seed = 0;
  logic [15:0] len = 0;
  logic busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we;
  logic [15:0] err_cnt;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0] wb_sel;
  logic [31:0] wb_dat_i = 0;
  logic wb_ack = 0, wb_err = 0, wb_stall = 0;
`ifdef WB_MEMTEST_ERRLOG_EN
  logic [31:0] fail_addr, fail_exp, fail_got;
`endif
  int n_tests = 0, n_fail = 0;

  wb_memtest_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .bus_err(bus_err), .err_cnt(err_cnt),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
`ifdef WB_MEMTEST_ERRLOG_EN
    , .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic err; logic [31:0] dat;} rsp_t;
  rsp_t q[$];
  rsp_t r;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
  int lat = 1, stall_pct = 0, err_at = 0, cyc_no = 0, wr_cnt = 0;
  int max_q = 0, stab_bad = 0, cyc_hi = 0, err_flag = 0;
  logic [31:0] stuck_mask = 0, p_adr = 0, p_dat = 0;
  logic p_hold = 0, p_we = 0, cyc_after_err = 1;

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [15:0] x;
    x = i[15:0];
    return s ^ {x, ~x};
  endfunction

  // RAM responder: in-order responses after lat cycles, optional random stall,
  // stuck-at-0 read bits and an err response on a chosen write.
  always @(negedge clk) begin
    if (err_flag == 1) begin
      cyc_after_err = wb_cyc;
      err_flag = 2;
    end
    if (wb_cyc === 1'b1) cyc_hi++;
    if (p_hold && (wb_stb !== 1'b1 || wb_adr !== p_adr || wb_dat_o !== p_dat || wb_we !== p_we)) stab_bad++;
    wb_ack = 0;
    wb_err = 0;
    wb_dat_i = 0;
    if (q.size() > 0 && q[0].due <= cyc_no) begin
      r = q.pop_front();
      if (r.err) begin
        wb_err = 1;
        err_flag = 1;
      end else begin
        wb_ack = 1;
        wb_dat_i = r.dat;
      end
    end
    wb_stall = $urandom_range(99) < stall_pct;
    if (wb_cyc === 1'b1 && wb_stb === 1'b1 && !wb_stall) begin
      if (wb_we) begin
        wr_cnt++;
        mem[wb_adr] = wb_dat_o;
        wr_adr_q.push_back(wb_adr);
        wr_dat_q.push_back(wb_dat_o);
        r = '{cyc_no + lat, wr_cnt == err_at, 32'h0};
      end else begin
        rd_adr_q.push_back(wb_adr);
        r = '{cyc_no + lat, 1'b0, (mem.exists(wb_adr) ? mem[wb_adr] : 32'h0) & ~stuck_mask};
      end
      q.push_back(r);
      if (q.size() > max_q) max_q = q.size();
    end
    p_hold = wb_cyc === 1'b1 && wb_stb === 1'b1 && wb_stall;
    p_adr = wb_adr;
    p_dat = wb_dat_o;
    p_we = wb_we;
    cyc_no++;
  end

  task automatic clear_resp();
    q.delete();
    wr_adr_q.delete();
    wr_dat_q.delete();
    rd_adr_q.delete();
    wr_cnt = 0;
    max_q = 0;
    stab_bad = 0;
    cyc_hi = 0;
    err_flag = 0;
    p_hold = 0;
    cyc_after_err = 1;
  endtask

  // k = cycle after the start edge in which done was seen (LIMIT on timeout)
  task automatic run(input logic [31:0] a, input int n, input logic [31:0] s, input int sp,
                     input int l, input logic [31:0] sm, input int ea, input bit poke, output int k);
    @(posedge clk);
    #1;
    clear_resp();
    stall_pct = sp;
    lat = l;
    stuck_mask = sm;
    err_at = ea;
    start_addr = a;
    len = 16'(n);
    seed = s;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    k = 1;
    while (done !== 1'b1 && k < LIMIT) begin
      start = poke && ($urandom_range(1) == 0);
      @(negedge clk);
      k++;
    end
    start = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0", {busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we});
    end
    n_tests++;
    if ({err_cnt, wb_adr, wb_dat_o} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_values err_cnt=%h adr=%h dat=%h exp 0", err_cnt, wb_adr, wb_dat_o);
    end
    n_tests++;
    if (wb_sel !== 4'hF) begin
      n_fail++;
      $display("FAIL wb_sel got %h exp f", wb_sel);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int k;
    run(32'h100, 8, 32'hA5A5A5A5, 0, 1, 0, 0, 0, k);
    n_tests++;
    if (k !== 20) begin n_fail++; $display("FAIL clean_done_cycle got %0d exp 20", k); end
    n_tests++;
    if ({pass, bus_err, err_cnt} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL clean_status pass=%b bus_err=%b err_cnt=%0d exp 1 0 0", pass, bus_err, err_cnt);
    end
    n_tests++;
    if (wr_adr_q.size() != 8 || rd_adr_q.size() != 8) begin
      n_fail++;
      $display("FAIL clean_counts wr=%0d rd=%0d exp 8 8", wr_adr_q.size(), rd_adr_q.size());
    end
    for (int i = 0; i < 8 && i < wr_adr_q.size() && i < rd_adr_q.size(); i++) begin
      n_tests++;
      if (wr_adr_q[i] !== 32'h100 + 4 * i || wr_dat_q[i] !== pat(32'hA5A5A5A5, i) || rd_adr_q[i] !== 32'h100 + 4 * i) begin
        n_fail++;
        $display("FAIL clean_word%0d wr %h/%h rd %h exp %h/%h", i, wr_adr_q[i], wr_dat_q[i], rd_adr_q[i],
                 32'h100 + 4 * i, pat(32'hA5A5A5A5, i));
      end
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, pass} !== 3'b001) begin
      n_fail++;
      $display("FAIL clean_after busy/done/pass got %b exp 001", {busy, done, pass});
    end
  endtask

  task automatic test_stuck();
    int k, exp_n, first;
    logic [31:0] a, s;
    a = $urandom & 32'hFFFF_FFFC;
    s = $urandom;
    exp_n = 0;
    first = -1;
    for (int i = 0; i < 16; i++) if (pat(s, i) & 32'h8) begin
      exp_n++;
      if (first < 0) first = i;
    end
    run(a, 16, s, 0, 1, 32'h8, 0, 0, k);
    n_tests++;
    if (k >= LIMIT) begin n_fail++; $display("FAIL stuck_timeout got %0d cycles", k); end
    n_tests++;
    if (err_cnt !== 16'(exp_n)) begin n_fail++; $display("FAIL stuck_err_cnt got %0d exp %0d", err_cnt, exp_n); end
    n_tests++;
    if (pass !== (exp_n == 0)) begin n_fail++; $display("FAIL stuck_pass got %b exp %b", pass, exp_n == 0); end
`ifdef WB_MEMTEST_ERRLOG_EN
    n_tests++;
    if (fail_addr !== a + 4 * first || fail_exp !== pat(s, first) || fail_got !== (pat(s, first) & ~32'h8)) begin
      n_fail++;
      $display("FAIL stuck_log got %h/%h/%h exp %h/%h/%h", fail_addr, fail_exp, fail_got,
               a + 4 * first, pat(s, first), pat(s, first) & ~32'h8);
    end
`endif
  endtask

  task automatic test_stall();
    int k, n;
    logic [31:0] a, s, b;
    n = $urandom_range(20, 40);
    a = $urandom;
    s = $urandom;
    b = a & 32'hFFFF_FFFC;
    run(a, n, s, 50, 3, 0, 0, 0, k);
    n_tests++;
    if (k >= LIMIT) begin n_fail++; $display("FAIL stall_timeout got %0d cycles", k); end
    n_tests++;
    if (max_q > 4) begin n_fail++; $display("FAIL stall_outstanding got %0d exp <=4", max_q); end
    n_tests++;
    if (stab_bad != 0) begin n_fail++; $display("FAIL stall_stability got %0d changes exp 0", stab_bad); end
    n_tests++;
    if ({pass, err_cnt} !== {1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL stall_status pass=%b err_cnt=%0d exp 1 0", pass, err_cnt);
    end
    n_tests++;
    if (wr_adr_q.size() != n || rd_adr_q.size() != n) begin
      n_fail++;
      $display("FAIL stall_counts wr=%0d rd=%0d exp %0d", wr_adr_q.size(), rd_adr_q.size(), n);
    end
    for (int i = 0; i < n && i < wr_adr_q.size() && i < rd_adr_q.size(); i++) begin
      n_tests++;
      if (wr_adr_q[i] !== b + 4 * i || wr_dat_q[i] !== pat(s, i) || rd_adr_q[i] !== b + 4 * i) begin
        n_fail++;
        $display("FAIL stall_word%0d wr %h/%h rd %h exp %h/%h", i, wr_adr_q[i], wr_dat_q[i], rd_adr_q[i], b + 4 * i, pat(s, i));
      end
    end
  endtask

  task automatic test_bus_err();
    int k;
    run($urandom & 32'hFFFF_FFFC, 10, $urandom, 0, 1, 0, 5, 0, k);
    n_tests++;
    if (k !== 7) begin n_fail++; $display("FAIL buserr_done_cycle got %0d exp 7", k); end
    n_tests++;
    if (err_flag != 2 || cyc_after_err !== 1'b0) begin
      n_fail++;
      $display("FAIL buserr_cyc_drop got flag=%0d cyc=%b exp 2 0", err_flag, cyc_after_err);
    end
    n_tests++;
    if ({bus_err, pass} !== 2'b10) begin
      n_fail++;
      $display("FAIL buserr_status bus_err/pass got %b exp 10", {bus_err, pass});
    end
    @(negedge clk);
    n_tests++;
    if ({busy, bus_err, wb_cyc} !== 3'b010) begin
      n_fail++;
      $display("FAIL buserr_after busy/bus_err/cyc got %b exp 010", {busy, bus_err, wb_cyc});
    end
  endtask

  task automatic test_edges();
    int k;
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    run($urandom, 0, $urandom, 0, 1, 0, 0, 0, k);
    n_tests++;
    if (k !== 4) begin n_fail++; $display("FAIL len0_done_cycle got %0d exp 4", k); end
    n_tests++;
    if (pass !== 1'b1 || cyc_hi != 0 || wr_adr_q.size() != 0) begin
      n_fail++;
      $display("FAIL len0_status pass=%b cyc_cycles=%0d writes=%0d exp 1 0 0", pass, cyc_hi, wr_adr_q.size());
    end
    run(32'hFFFF_FFF8, 4, $urandom, 0, 1, 0, 0, 0, k);
    n_tests++;
    if (k !== 12 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_status done=%0d pass=%b exp 12 1", k, pass);
    end
    n_tests++;
    if (wr_adr_q.size() != 4) begin n_fail++; $display("FAIL wrap_count got %0d exp 4", wr_adr_q.size()); end
    for (int i = 0; i < 4 && i < wr_adr_q.size(); i++) begin
      n_tests++;
      if (wr_adr_q[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d got %h exp %h", i, wr_adr_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, w;
    @(posedge clk);
    #1;
    clear_resp();
    lat = 3;
    stall_pct = 0;
    stuck_mask = 0;
    err_at = 0;
    start_addr = $urandom;
    len = 12;
    seed = $urandom;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    w = 0;
    while (!(wb_cyc === 1'b1 && wb_we === 1'b0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (w >= 200) begin n_fail++; $display("FAIL midrst_reach_rd got %0d cycles exp <200", w); end
    rst_n = 0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we, err_cnt, wb_adr, wb_dat_o} !== 87'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs busy=%b cyc=%b stb=%b adr=%h dat=%h err_cnt=%0d exp 0",
               busy, wb_cyc, wb_stb, wb_adr, wb_dat_o, err_cnt);
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({busy, wb_cyc, err_cnt, bus_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL midrst_ignore busy=%b cyc=%b err_cnt=%0d bus_err=%b exp 0", busy, wb_cyc, err_cnt, bus_err);
    end
    run($urandom, 6, $urandom, 0, 1, 0, 0, 1, k);
    n_tests++;
    if (k !== 16 || pass !== 1'b1 || err_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_rerun done=%0d pass=%b err_cnt=%0d exp 16 1 0", k, pass, err_cnt);
    end
    n_tests++;
    if (wr_adr_q.size() != 6 || rd_adr_q.size() != 6) begin
      n_fail++;
      $display("FAIL midrst_ignored_start wr=%0d rd=%0d exp 6 6", wr_adr_q.size(), rd_adr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck();
    test_stall();
    test_bus_err();
    test_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
